// File: rtl/ex_iter_div.sv
// Multi-cycle restoring radix-2 divider for the EX stage: signed/unsigned quotient and remainder.
// Optional EX_ITER_DIV_EARLY_OUT_EN finishes in one cycle when |dividend| < |divisor|.
module ex_iter_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               flush_i,
  input  logic               hold_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  dvd_q;   // dividend magnitude, shifted out MSB first; becomes the quotient
  logic [WIDTH-1:0]  dvs_q;
  logic [WIDTH:0]    rem_q;
  logic              q_neg_q;
  logic              r_neg_q;

  logic [WIDTH-1:0]  dvd_mag;
  logic [WIDTH-1:0]  dvs_mag;
  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    diff;
  logic              ge;
  logic [WIDTH-1:0]  quo_fix;
  logic [WIDTH-1:0]  rem_fix;

  always_comb begin
    dvd_mag = (signed_i && dividend_i[WIDTH-1]) ? (~dividend_i + One) : dividend_i;
    dvs_mag = (signed_i && divisor_i[WIDTH-1]) ? (~divisor_i + One) : divisor_i;
    shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    ge      = shifted >= {1'b0, dvs_q};
    diff    = shifted - {1'b0, dvs_q};
    quo_fix = q_neg_q ? (~dvd_q + One) : dvd_q;
    rem_fix = r_neg_q ? (~rem_q[WIDTH-1:0] + One) : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      result_o   <= '0;
    end else if (flush_i) begin
      state_q    <= StIdle;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            dvd_q   <= dvd_mag;
            dvs_q   <= dvs_mag;
            rem_q   <= '0;
            cnt_q   <= CntW'(WIDTH);
            q_neg_q <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            r_neg_q <= signed_i & dividend_i[WIDTH-1];
            if (divisor_i == '0) begin
              result_o   <= {dividend_i, {WIDTH{1'b1}}};
              div_zero_o <= 1'b1;
              done_o     <= 1'b1;
              state_q    <= StDone;
`ifdef EX_ITER_DIV_EARLY_OUT_EN
            end else if (dvd_mag < dvs_mag) begin
              result_o <= {dividend_i, {WIDTH{1'b0}}};
              done_o   <= 1'b1;
              state_q  <= StDone;
`endif
            end else begin
              busy_o  <= 1'b1;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q <= ge ? diff : shifted;
          dvd_q <= {dvd_q[WIDTH-2:0], ge};
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result_o <= {rem_fix, quo_fix};
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          if (!hold_i) begin
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_iter_div.sv
// Directed self-checking bench for ex_iter_div (WIDTH=32): latency, signs, divide-by-zero,
// flush, hold and reset behaviour.
module tb_ex_iter_div;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic           signed_i = 1'b0;
  logic [W-1:0]   dividend_i = '0;
  logic [W-1:0]   divisor_i = '0;
  logic           flush_i = 1'b0;
  logic           hold_i = 1'b0;
  logic           busy_o;
  logic           done_o;
  logic [2*W-1:0] result_o;
  logic           div_zero_o;

  int checks = 0;
  int errors = 0;

  ex_iter_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .flush_i    (flush_i),
    .hold_i     (hold_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    start_i    = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // Edges after the accepting edge until done_o is seen (0 = already high).
  task automatic wait_done(output int lat, output logic b_first, output logic b_last);
    lat     = 0;
    b_first = busy_o;
    b_last  = busy_o;
    while (!done_o && lat < 100) begin
      b_last = busy_o;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic leave_done(input string tag);
    @(posedge clk);
    #1 check(tag, 64'(done_o), 64'd0);
  endtask

  int   lat;
  logic bf, bl, seen;
  logic [63:0] held;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_dz", 64'(div_zero_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    rst = 1'b0;

    issue(32'd100, 32'd7, 1'b0);
    wait_done(lat, bf, bl);
    check("u100_7_lat", 64'(lat), 64'd33);
    check("u100_7_busy_first", 64'(bf), 64'd1);
    check("u100_7_busy_fix", 64'(bl), 64'd1);
    check("u100_7_busy_done", 64'(busy_o), 64'd0);
    check("u100_7_res", result_o, 64'h00000002_0000000E);
    check("u100_7_dz", 64'(div_zero_o), 64'd0);
    leave_done("u100_7_exit");

    issue(32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done(lat, bf, bl);
    check("s_m7_2_res", result_o, 64'hFFFFFFFF_FFFFFFFD);
    leave_done("s_m7_2_exit");

    issue(32'd7, 32'hFFFFFFFE, 1'b1);
    wait_done(lat, bf, bl);
    check("s_7_m2_res", result_o, 64'h00000001_FFFFFFFD);
    leave_done("s_7_m2_exit");

    issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done(lat, bf, bl);
    check("s_ovf_res", result_o, 64'h00000000_80000000);
    check("s_ovf_dz", 64'(div_zero_o), 64'd0);
    leave_done("s_ovf_exit");

    issue(32'd5, 32'd0, 1'b0);
    wait_done(lat, bf, bl);
    check("u_dz_lat", 64'(lat), 64'd0);
    check("u_dz_res", result_o, 64'h00000005_FFFFFFFF);
    check("u_dz_flag", 64'(div_zero_o), 64'd1);
    leave_done("u_dz_exit");
    check("u_dz_flag_clr", 64'(div_zero_o), 64'd0);

    issue(32'd5, 32'd0, 1'b1);
    wait_done(lat, bf, bl);
    check("s_dz_lat", 64'(lat), 64'd0);
    check("s_dz_res", result_o, 64'h00000005_FFFFFFFF);
    check("s_dz_flag", 64'(div_zero_o), 64'd1);
    leave_done("s_dz_exit");

    // Flush ten cycles into a divide, then make sure nothing completes.
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    check("flush_busy", 64'(busy_o), 64'd0);
    check("flush_done", 64'(done_o), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done_o) seen = 1'b1;
    end
    check("flush_no_done", 64'(seen), 64'd0);

    issue(32'd9, 32'd3, 1'b0);
    wait_done(lat, bf, bl);
    check("u9_3_lat", 64'(lat), 64'd33);
    check("u9_3_res", result_o, 64'h00000000_00000003);

    // Hold DONE for three edges with a new request pending.
    held       = result_o;
    hold_i     = 1'b1;
    start_i    = 1'b1;
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    signed_i   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_done_%0d", i), 64'(done_o), 64'd1);
      check($sformatf("hold_res_%0d", i), result_o, held);
      check($sformatf("hold_busy_%0d", i), 64'(busy_o), 64'd0);
    end
    hold_i = 1'b0;
    @(posedge clk);
    #1;
    check("hold_exit_done", 64'(done_o), 64'd0);
    check("hold_exit_busy", 64'(busy_o), 64'd0);
    check("hold_keep_res", result_o, held);
    @(posedge clk);
    #1 start_i = 1'b0;
    check("hold_reaccept_busy", 64'(busy_o), 64'd1);
    wait_done(lat, bf, bl);
    check("u50_5_res", result_o, 64'h00000000_0000000A);
    leave_done("u50_5_exit");

    issue(32'd3, 32'd10, 1'b0);
    wait_done(lat, bf, bl);
`ifdef EX_ITER_DIV_EARLY_OUT_EN
    check("u3_10_lat", 64'(lat), 64'd0);
`else
    check("u3_10_lat", 64'(lat), 64'd33);
`endif
    check("u3_10_res", result_o, 64'h00000003_00000000);
    leave_done("u3_10_exit");

    // Reset mid-operation clears everything, including the last result.
    issue(32'd9, 32'd3, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_done", 64'(done_o), 64'd0);
    check("midrst_res", result_o, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
